// File: rtl/tmr_pkg.sv
// Shared types and constants for the dynamic TMR mode scheduler.
package tmr_pkg;

    typedef enum logic [1:0] {
        SIMPLEX  = 2'd0,
        WARMUP   = 2'd1,
        TMR      = 2'd2,
        COOLDOWN = 2'd3
    } mode_e;

    localparam logic [2:0] EN_SIMPLEX = 3'b001;
    localparam logic [2:0] EN_TMR     = 3'b111;

    localparam int unsigned ERR_RATE_W = 4;
    localparam logic [ERR_RATE_W-1:0] ERR_SAT = 4'd15;

    // Replica enable pattern for a given mode: only replica 0 in simplex.
    function automatic logic [2:0] en_of(input mode_e m);
        return (m == SIMPLEX) ? EN_SIMPLEX : EN_TMR;
    endfunction

endpackage

// File: rtl/err_rate_mon.sv
// Windowed error-rate monitor: counts err_evt per WINDOW cycles, saturating,
// and publishes the count of the last completed window.
module err_rate_mon
    import tmr_pkg::*;
#(
    parameter int unsigned WINDOW = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  err_evt,
    output logic [ERR_RATE_W-1:0] err_rate
);

    localparam int unsigned WIN_W = $clog2(WINDOW);

    logic [WIN_W-1:0]      win_cnt;
    logic [ERR_RATE_W-1:0] err_cnt;
    logic                  win_end_c;
    logic [ERR_RATE_W-1:0] err_inc_c;

    assign win_end_c = (win_cnt == WIN_W'(WINDOW - 1));
    // An event on the closing cycle still belongs to the closing window.
    assign err_inc_c = (err_evt && (err_cnt != ERR_SAT)) ? err_cnt + ERR_RATE_W'(1) : err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt  <= '0;
            err_cnt  <= '0;
            err_rate <= '0;
        end else if (win_end_c) begin
            win_cnt  <= '0;
            err_cnt  <= '0;
            err_rate <= err_inc_c;
        end else begin
            win_cnt  <= win_cnt + WIN_W'(1);
            err_cnt  <= err_inc_c;
        end
    end

endmodule

// File: rtl/tmr_mode_sched.sv
// Mode controller for the dynamic TMR datapath: chooses simplex or voted TMR
// from synchronised hazard sensors and the windowed error rate.
module tmr_mode_sched
    import tmr_pkg::*;
#(
    parameter int unsigned WINDOW   = 256,
    parameter int unsigned ERR_TH   = 5,
    parameter int unsigned WARM_CYC = 4,
    parameter int unsigned HOLD_CYC = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  f1,
    input  logic                  f2,
    input  logic                  b1,
    input  logic                  b2,
    input  logic                  err_evt,
    output logic [2:0]            en,
    output logic                  state,
    output logic                  sync,
    output logic [ERR_RATE_W-1:0] err_rate
);

    localparam int unsigned WARM_W = $clog2(WARM_CYC + 1);
    localparam int unsigned HOLD_W = $clog2(HOLD_CYC + 1);

    logic [3:0]        sens_meta;
    logic [3:0]        sens_sync;
    logic [2:0]        sens_sum_c;
    logic              trig_c;
    mode_e             fsm;
    mode_e             fsm_nxt;
    logic [WARM_W-1:0] warm_cnt;
    logic [WARM_W-1:0] warm_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_nxt;
    logic              sync_nxt;

    err_rate_mon #(.WINDOW(WINDOW)) u_err_rate_mon (
        .clk      (clk),
        .rst_n    (rst_n),
        .err_evt  (err_evt),
        .err_rate (err_rate)
    );

    // Two-flop synchronisers for the asynchronous sensors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sens_meta <= '0;
            sens_sync <= '0;
        end else begin
            sens_meta <= {b2, b1, f2, f1};
            sens_sync <= sens_meta;
        end
    end

    assign sens_sum_c = 3'(sens_sync[0]) + 3'(sens_sync[1]) + 3'(sens_sync[2]) + 3'(sens_sync[3]);
    assign trig_c     = (sens_sum_c >= 3'd3) || (err_rate > ERR_RATE_W'(ERR_TH));

    // Next-state logic; warm-up always completes, trig beats hold expiry.
    always_comb begin
        fsm_nxt  = fsm;
        warm_nxt = warm_cnt;
        hold_nxt = hold_cnt;
        sync_nxt = 1'b0;
        unique case (fsm)
            SIMPLEX: begin
                if (trig_c) begin
                    fsm_nxt  = WARMUP;
                    warm_nxt = '0;
                    sync_nxt = 1'b1;
                end
            end
            WARMUP: begin
                if (warm_cnt == WARM_W'(WARM_CYC - 1)) begin
                    fsm_nxt = TMR;
                end else begin
                    warm_nxt = warm_cnt + WARM_W'(1);
                end
            end
            TMR: begin
                if (!trig_c) begin
                    fsm_nxt  = COOLDOWN;
                    hold_nxt = '0;
                end
            end
            COOLDOWN: begin
                if (trig_c) begin
                    fsm_nxt  = TMR;
                    hold_nxt = '0;
                end else if (hold_cnt == HOLD_W'(HOLD_CYC - 1)) begin
                    fsm_nxt = SIMPLEX;
                end else begin
                    hold_nxt = hold_cnt + HOLD_W'(1);
                end
            end
        endcase
    end

    // State register with outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm      <= SIMPLEX;
            warm_cnt <= '0;
            hold_cnt <= '0;
            en       <= EN_SIMPLEX;
            state    <= 1'b0;
            sync     <= 1'b0;
        end else begin
            fsm      <= fsm_nxt;
            warm_cnt <= warm_nxt;
            hold_cnt <= hold_nxt;
            en       <= en_of(fsm_nxt);
            state    <= (fsm_nxt == TMR) || (fsm_nxt == COOLDOWN);
            sync     <= sync_nxt;
        end
    end

endmodule
